// File: rtl/vec_norm_pkg.sv
// Shared types and width helpers for the vector-norm square-root unit.
// Optional rounding build: define VEC_NORM_ROUND_EN.
package vec_norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    OUT
  } state_t;

  function automatic int sum_width(input int w, input int ch);
    return 2 * w + $clog2(ch);
  endfunction

  function automatic int int_width(input int sw);
    return (sw + 1) / 2;
  endfunction

endpackage

// File: rtl/vec_norm_sqrt_isqrt.sv
// Restoring bit-serial integer square root, one root bit per clock, MSB first.
// The start cycle already performs the first step so the engine needs RB edges.
module isqrt_bitserial #(
  parameter int RADW = 66,
  parameter int RB   = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RADW-1:0] radicand,
  output logic [RB-1:0]   root,
  output logic [RB+1:0]   rem,
  output logic            done
);

  localparam int CW  = $clog2(RB + 1);
  localparam int RMW = RB + 2;

  logic [CW-1:0]    cnt;
  logic [2*RB-1:0]  rad_q;
  logic [2*RB-1:0]  rad_src;
  logic [2*RB-1:0]  rad_n;
  logic [RMW-1:0]   rem_src;
  logic [RMW-1:0]   rem_n;
  logic [RB-1:0]    root_src;
  logic [RB-1:0]    root_n;
  logic [RMW+1:0]   cur;
  logic [RMW+1:0]   trial;
  logic [RMW+1:0]   diff;
  logic             take;

  assign rad_src  = start ? (2*RB)'(radicand) : rad_q;
  assign rem_src  = start ? '0 : rem;
  assign root_src = start ? '0 : root;

  assign cur   = {rem_src, rad_src[2*RB-1 -: 2]};
  assign trial = {2'b00, root_src, 2'b01};
  assign diff  = cur - trial;
  assign take  = cur >= trial;

  assign rem_n  = take ? diff[RMW-1:0] : cur[RMW-1:0];
  assign root_n = {root_src[RB-2:0], take};
  assign rad_n  = {rad_src[2*RB-3:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rad_q <= '0;
      rem   <= '0;
      root  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rad_q <= rad_n;
        rem   <= rem_n;
        root  <= root_n;
        cnt   <= CW'(RB - 1);
        done  <= (RB == 1);
      end else if (cnt != '0) begin
        rad_q <= rad_n;
        rem   <= rem_n;
        root  <= root_n;
        cnt   <= cnt - CW'(1);
        done  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/vec_norm_sqrt.sv
// Euclidean norm of CH unsigned components: serial squaring then bit-serial root.
// Define VEC_NORM_ROUND_EN for a guard bit and round-to-nearest with saturation.
import vec_norm_pkg::*;

module vec_norm_sqrt #(
  parameter int W    = 16,
  parameter int CH   = 2,
  parameter int FRAC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CH*W-1:0]     data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [int_width(sum_width(W, CH))-1:0] yint_o,
  output logic [FRAC-1:0]     ydec_o,
  output logic                exact_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int SW = sum_width(W, CH);
  localparam int IW = int_width(SW);
  localparam int R  = IW + FRAC;
`ifdef VEC_NORM_ROUND_EN
  localparam int RB = R + 1;
`else
  localparam int RB = R;
`endif
  localparam int RADW = SW + 2 * (RB - IW);
  localparam int JW   = (W > 1) ? $clog2(W) : 1;
  localparam int KW   = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(W - 1);
  localparam logic [KW-1:0] K_LAST = KW'(CH - 1);

  state_t          state;
  logic [CH*W-1:0] data_q;
  logic [SW-1:0]   acc;
  logic [JW-1:0]   j;
  logic [KW-1:0]   k;
  logic            start;
  logic [W-1:0]    cur;
  logic [SW-1:0]   addend;
  logic [RADW-1:0] radicand;
  logic [RB-1:0]   root;
  logic [RB+1:0]   rem;
  logic            done;
  logic [R-1:0]    res;
  logic            exact_c;

  // Partial products go straight into the accumulator, one multiplier bit per clock
  assign cur      = data_q[k*W +: W];
  assign addend   = cur[j] ? (SW'(cur) << j) : '0;
  assign radicand = {acc, {(RADW-SW){1'b0}}};

  isqrt_bitserial #(
    .RADW(RADW),
    .RB  (RB)
  ) u_isqrt (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (start),
    .radicand(radicand),
    .root    (root),
    .rem     (rem),
    .done    (done)
  );

`ifdef VEC_NORM_ROUND_EN
  logic [R-1:0] base;
  assign base    = root[RB-1:1];
  assign res     = (root[0] && !(&base)) ? base + R'(1) : base;
  assign exact_c = (rem == '0) && !root[0];
`else
  assign res     = root;
  assign exact_c = (rem == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      yint_o  <= '0;
      ydec_o  <= '0;
      exact_o <= 1'b0;
      data_q  <= '0;
      acc     <= '0;
      j       <= '0;
      k       <= '0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            data_q  <= data_i;
            acc     <= '0;
            j       <= '0;
            k       <= '0;
            ready_o <= 1'b0;
            state   <= SQUARE;
          end
        end
        SQUARE: begin
          acc <= acc + addend;
          if (j == J_LAST) begin
            j <= '0;
            if (k == K_LAST) begin
              start <= 1'b1;
              state <= ROOT;
            end else begin
              k <= k + KW'(1);
            end
          end else begin
            j <= j + JW'(1);
          end
        end
        ROOT: begin
          if (done) begin
            yint_o  <= res[R-1:FRAC];
            ydec_o  <= res[FRAC-1:0];
            exact_o <= exact_c;
            valid_o <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vec_norm_sqrt.md
Name: vec_norm_sqrt

Overview:
- Computes the Euclidean norm sqrt(x0^2 + x1^2 + ... + x(CH-1)^2) of CH unsigned W-bit components, in fixed point (IW integer bits, FRAC fractional bits).
- Generalises the two-input sqrt block to:
  - any channel count;
  - parametrised width and fraction;
  - a valid/ready handshake on both sides;
  - a fixed, deterministic latency, using a bit-serial digit-by-digit root instead of Newton/division.
- Sits in the arithmetic library as a multi-cycle datapath unit.

Parameters:
- W, 16, width of each unsigned input component.
- CH, 2, number of components (>=1).
- FRAC, 16, fractional bits of the result.
- Derived localparams, not overridable:
  - SW = 2*W + $clog2(CH) (sum-of-squares width; for CH=1, SW = 2*W);
  - IW = (SW+1)/2;
  - R = IW + FRAC.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  CH*W  packed components; component k occupies bits [k*W+W-1 : k*W].
- valid_i  in  1  input valid.
- ready_o  out  1  block can accept an input.
- yint_o  out  IW  integer part of the result.
- ydec_o  out  FRAC  fractional part of the result.
- exact_o  out  1  remainder is zero (the root is exact at FRAC precision).
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: FSM=IDLE, ready_o=1, valid_o=0, yint_o=0, ydec_o=0, exact_o=0, all internal registers 0.
- FSM states: IDLE, SQUARE, ROOT, OUT.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, capture data_i, clear the accumulator and go to SQUARE.
- SQUARE:
  - Shift-add squaring, one multiplier bit per cycle, W cycles per component, components in order k=0..CH-1.
  - Each square (2W bits) is added into an SW-bit accumulator.
  - Lasts exactly CH*W cycles, then goes to ROOT.
- ROOT:
  - Restoring bit-serial integer sqrt of {acc, 2*FRAC zero bits}, producing one root bit per cycle, MSB first.
  - Lasts exactly R cycles, then goes to OUT.
- OUT:
  - valid_o=1 and the outputs are stable.
  - On ready_i, go to IDLE, drop valid_o and raise ready_o in the next cycle.
  - Outputs hold their last value after the handshake.
- Latency: valid_o rises exactly 1 + CH*W + R clocks after the accepting edge (W=16, CH=2, FRAC=16: R=33, latency 66).
- ready_o=0 in SQUARE, ROOT and OUT. No overlap: a new input is accepted no earlier than the cycle after the output handshake.
- Arithmetic:
  - All values unsigned; the accumulator cannot overflow by choice of SW.
  - The result is floor(sqrt(sum) * 2^FRAC), split as yint_o = root[R-1:FRAC] and ydec_o = root[FRAC-1:0].
  - exact_o = (final remainder == 0).
- Boundaries:
  - All-zero input gives 0/0 with exact_o=1.
  - All-ones input does not saturate and fits IW.
  - valid_i while busy is ignored; no capture.
  - ready_i with valid_o=0 is ignored.
  - rst_i asserted mid-SQUARE/ROOT/OUT aborts immediately to reset values; partial results are never emitted.

Optional Feature:
- Macro: VEC_NORM_ROUND_EN.
- Defined:
  - ROOT runs R+1 cycles, computing one guard bit, and the result is rounded to nearest (guard=1 adds 1 LSB); latency becomes 2 + CH*W + R.
  - If the root is all ones, it saturates to all ones instead of wrapping.
  - exact_o means the remainder is zero and the guard bit is zero.
- Undefined: truncation (floor), as described in Behaviour.

Decomposition:
- Package vec_norm_pkg holds:
  - the state enum type (IDLE, SQUARE, ROOT, OUT);
  - width helper functions (sum width, integer width) used for SW/IW/R.
- Sub-module isqrt_bitserial, the ROOT engine, parametrised by radicand width and root width.
  - Interface: start, radicand in, root/remainder out, done pulse.
- The top level keeps the FSM, the squaring accumulator and the handshake.

Test Plan:
- W=16, CH=2, FRAC=16: data (3,4) -> yint_o=5, ydec_o=0, exact_o=1; valid_o exactly 66 cycles after accept.
- (1,1) -> yint_o=1, ydec_o=27145 (0x6A09), exact_o=0. With VEC_NORM_ROUND_EN: ydec_o=27146, valid_o at cycle 67.
- Input values:
  - (0,0) -> 0/0, exact_o=1.
  - (0xFFFF,0xFFFF) -> yint_o=92680, no overflow.
  - CH=3, inputs (2,3,6) -> yint_o=7, ydec_o=0, exact_o=1.
- Backpressure: hold ready_i=0 for 10 cycles in OUT -> valid_o and the outputs are stable, and valid_i pulses are ignored. After ready_i, ready_o=1 one cycle later, and back-to-back inputs produce results in order.
- Assert rst_i at cycle 20 of SQUARE and again mid-ROOT -> outputs return to reset values asynchronously, no valid_o. The next input (3,4) completes correctly.
